// File: rtl/id_stage_param_if.sv
// Decode-stage bundle: ID-side inputs, writeback port, hazard controls and ID/EX outputs.
interface id_stage_param_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CTRL_W = 16
);
  logic              valid_d;
  logic [31:0]       instruction;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   pc_plus_4;
  logic [CTRL_W-1:0] ctrl_i;
  logic [XLEN-1:0]   imm_i;
  logic              writeback_control;
  logic [4:0]        rd;
  logic [XLEN-1:0]   writeback_data;
  logic              stall_d;
  logic              flush_d;

  logic [4:0]        id_ex_rs1_d_wire;
  logic [4:0]        id_ex_rs2_d_wire;
  logic              valid_e;
  logic [CTRL_W-1:0] ctrl_e;
  logic [XLEN-1:0]   immediate;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  logic [4:0]        rd_out;
  logic [4:0]        id_ex_rs1_d_reg;
  logic [4:0]        id_ex_rs2_d_reg;
  logic [XLEN-1:0]   id_ex_pc;
  logic [XLEN-1:0]   id_ex_pc_plus_4;
  logic              illegal_reg_e;

  modport master (
    output valid_d, instruction, pc, pc_plus_4, ctrl_i, imm_i,
           writeback_control, rd, writeback_data, stall_d, flush_d,
    input  id_ex_rs1_d_wire, id_ex_rs2_d_wire, valid_e, ctrl_e, immediate,
           rs1_data, rs2_data, rd_out, id_ex_rs1_d_reg, id_ex_rs2_d_reg,
           id_ex_pc, id_ex_pc_plus_4, illegal_reg_e
  );

  modport slave (
    input  valid_d, instruction, pc, pc_plus_4, ctrl_i, imm_i,
           writeback_control, rd, writeback_data, stall_d, flush_d,
    output id_ex_rs1_d_wire, id_ex_rs2_d_wire, valid_e, ctrl_e, immediate,
           rs1_data, rs2_data, rd_out, id_ex_rs1_d_reg, id_ex_rs2_d_reg,
           id_ex_pc, id_ex_pc_plus_4, illegal_reg_e
  );
endinterface

// File: rtl/id_stage_param.sv
// Parametrised decode stage: register file with write-through bypass and the ID/EX pipeline register.
module id_stage_param #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREG     = 32,
  parameter int unsigned CTRL_W   = 16,
  parameter int unsigned RF_RESET = 1
) (
  input logic              clk,
  input logic              reset,
  id_stage_param_if.slave  bus
);
  localparam int unsigned AW = $clog2(NREG);
  localparam int unsigned RW = 5;

  logic [XLEN-1:0]   r_rf [NREG];

  logic [RW-1:0]     w_rs1;
  logic [RW-1:0]     w_rs2;
  logic [RW-1:0]     w_rdf;
  logic              w_rs1_ok;
  logic              w_rs2_ok;
  logic              w_wr_en;
  logic              w_illegal;
  logic [XLEN-1:0]   w_rs1_next;
  logic [XLEN-1:0]   w_rs2_next;
  logic              w_refresh1;
  logic              w_refresh2;
  logic              w_unused_instr;

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [XLEN-1:0]   r_imm;
  logic [XLEN-1:0]   r_rs1_data;
  logic [XLEN-1:0]   r_rs2_data;
  logic [RW-1:0]     r_rd;
  logic [RW-1:0]     r_rs1_idx;
  logic [RW-1:0]     r_rs2_idx;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_pc4;
  logic              r_illegal;

  assign w_rs1 = bus.instruction[19:15];
  assign w_rs2 = bus.instruction[24:20];
  assign w_rdf = bus.instruction[11:7];
  assign w_unused_instr = ^{bus.instruction[31:25], bus.instruction[6:0]};

  // Out-of-range indices read as zero and are never allowed to alias onto a low register.
  assign w_rs1_ok  = (w_rs1 != '0) && (32'(w_rs1) < NREG);
  assign w_rs2_ok  = (w_rs2 != '0) && (32'(w_rs2) < NREG);
  assign w_wr_en   = bus.writeback_control && (bus.rd != '0) && (32'(bus.rd) < NREG);
  assign w_illegal = bus.valid_d && ((32'(w_rs1) >= NREG) || (32'(w_rs2) >= NREG) ||
                                     (32'(w_rdf) >= NREG));

  // Held operands track a writeback that targets them while the stage is stalled.
  assign w_refresh1 = bus.writeback_control && (bus.rd != '0) && (bus.rd == r_rs1_idx);
  assign w_refresh2 = bus.writeback_control && (bus.rd != '0) && (bus.rd == r_rs2_idx);

  always_comb begin
    w_rs1_next = '0;
    w_rs2_next = '0;
    if (w_rs1_ok) begin
      w_rs1_next = (bus.writeback_control && (bus.rd == w_rs1)) ? bus.writeback_data
                                                                : r_rf[w_rs1[AW-1:0]];
    end
    if (w_rs2_ok) begin
      w_rs2_next = (bus.writeback_control && (bus.rd == w_rs2)) ? bus.writeback_data
                                                                : r_rf[w_rs2[AW-1:0]];
    end
  end

  // Register file: single posedge write, writes suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (RF_RESET != 0) begin
        for (int unsigned i = 0; i < NREG; i++) begin
          r_rf[AW'(i)] <= '0;
        end
      end
    end else if (w_wr_en) begin
      r_rf[bus.rd[AW-1:0]] <= bus.writeback_data;
    end
  end

  // ID/EX register: reset > flush > stall > load.
  always_ff @(posedge clk) begin
    if (reset || bus.flush_d) begin
      r_valid    <= 1'b0;
      r_ctrl     <= '0;
      r_imm      <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_rd       <= '0;
      r_rs1_idx  <= '0;
      r_rs2_idx  <= '0;
      r_pc       <= '0;
      r_pc4      <= '0;
      r_illegal  <= 1'b0;
    end else if (bus.stall_d) begin
      if (w_refresh1) r_rs1_data <= bus.writeback_data;
      if (w_refresh2) r_rs2_data <= bus.writeback_data;
    end else begin
      r_valid    <= bus.valid_d;
      r_ctrl     <= bus.ctrl_i;
      r_imm      <= bus.imm_i;
      r_rs1_data <= w_rs1_next;
      r_rs2_data <= w_rs2_next;
      r_rd       <= w_rdf;
      r_rs1_idx  <= w_rs1;
      r_rs2_idx  <= w_rs2;
      r_pc       <= bus.pc;
      r_pc4      <= bus.pc_plus_4;
      r_illegal  <= w_illegal;
    end
  end

  assign bus.id_ex_rs1_d_wire = w_rs1;
  assign bus.id_ex_rs2_d_wire = w_rs2;
  assign bus.valid_e          = r_valid;
  assign bus.ctrl_e           = r_ctrl;
  assign bus.immediate        = r_imm;
  assign bus.rs1_data         = r_rs1_data;
  assign bus.rs2_data         = r_rs2_data;
  assign bus.rd_out           = r_rd;
  assign bus.id_ex_rs1_d_reg  = r_rs1_idx;
  assign bus.id_ex_rs2_d_reg  = r_rs2_idx;
  assign bus.id_ex_pc         = r_pc;
  assign bus.id_ex_pc_plus_4  = r_pc4;
  assign bus.illegal_reg_e    = r_illegal;
endmodule

// File: tb/tb_id_stage_param.sv
// Drives a 32-register and a 16-register (RV32E) decode stage with identical stimulus and checks both against a reference model.
module tb_id_stage_param;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned CTRL_W = 16;

  typedef struct packed {
    logic              valid;
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   rs1d;
    logic [XLEN-1:0]   rs2d;
    logic [4:0]        rdo;
    logic [4:0]        rs1r;
    logic [4:0]        rs2r;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc4;
    logic              ill;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_stage_param_if #(.XLEN(XLEN), .CTRL_W(CTRL_W)) bus32 ();
  id_stage_param_if #(.XLEN(XLEN), .CTRL_W(CTRL_W)) bus16 ();

  id_stage_param #(.XLEN(XLEN), .NREG(32), .CTRL_W(CTRL_W), .RF_RESET(1)) dut32 (
    .clk(clk), .reset(reset), .bus(bus32));
  id_stage_param #(.XLEN(XLEN), .NREG(16), .CTRL_W(CTRL_W), .RF_RESET(1)) dut16 (
    .clk(clk), .reset(reset), .bus(bus16));

  int n_tests = 0;
  int n_fail  = 0;

  logic              s_reset, s_valid, s_wbc, s_stall, s_flush;
  logic [31:0]       s_instr;
  logic [XLEN-1:0]   s_pc, s_pc4, s_imm, s_wbd;
  logic [CTRL_W-1:0] s_ctrl;
  logic [4:0]        s_rd;

  logic [XLEN-1:0] m_rf [2][32];
  exp_t            m_exp [2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int nreg_of(input int k);
    return (k == 0) ? 32 : 16;
  endfunction

  function automatic logic [XLEN-1:0] read_op(input int k, input logic [4:0] idx);
    if (idx == 0 || int'(idx) >= nreg_of(k)) return '0;
    if (s_wbc && s_rd == idx) return s_wbd;
    return m_rf[k][idx];
  endfunction

  // Reference: next ID/EX contents from the current inputs, then the register-file commit.
  task automatic model_step(input int k);
    exp_t e;
    int   n;
    logic [4:0] a, b, d;
    n = nreg_of(k);
    e = m_exp[k];
    a = s_instr[19:15];
    b = s_instr[24:20];
    d = s_instr[11:7];
    if (s_reset || s_flush) begin
      e = '0;
    end else if (s_stall) begin
      if (s_wbc && s_rd != 0 && s_rd == e.rs1r) e.rs1d = s_wbd;
      if (s_wbc && s_rd != 0 && s_rd == e.rs2r) e.rs2d = s_wbd;
    end else begin
      e.valid = s_valid;
      e.ctrl  = s_ctrl;
      e.imm   = s_imm;
      e.rs1d  = read_op(k, a);
      e.rs2d  = read_op(k, b);
      e.rdo   = d;
      e.rs1r  = a;
      e.rs2r  = b;
      e.pc    = s_pc;
      e.pc4   = s_pc4;
      e.ill   = s_valid && (int'(a) >= n || int'(b) >= n || int'(d) >= n);
    end
    m_exp[k] = e;
    if (s_reset) begin
      for (int i = 0; i < 32; i++) m_rf[k][i] = '0;
    end else if (s_wbc && s_rd != 0 && int'(s_rd) < n) begin
      m_rf[k][s_rd] = s_wbd;
    end
  endtask

  task automatic compare(input string p, input exp_t o, input exp_t e);
    check({p, ".valid_e"},         64'(o.valid), 64'(e.valid));
    check({p, ".ctrl_e"},          64'(o.ctrl),  64'(e.ctrl));
    check({p, ".immediate"},       64'(o.imm),   64'(e.imm));
    check({p, ".rs1_data"},        64'(o.rs1d),  64'(e.rs1d));
    check({p, ".rs2_data"},        64'(o.rs2d),  64'(e.rs2d));
    check({p, ".rd_out"},          64'(o.rdo),   64'(e.rdo));
    check({p, ".id_ex_rs1_d_reg"}, 64'(o.rs1r),  64'(e.rs1r));
    check({p, ".id_ex_rs2_d_reg"}, 64'(o.rs2r),  64'(e.rs2r));
    check({p, ".id_ex_pc"},        64'(o.pc),    64'(e.pc));
    check({p, ".id_ex_pc_plus_4"}, 64'(o.pc4),   64'(e.pc4));
    check({p, ".illegal_reg_e"},   64'(o.ill),   64'(e.ill));
  endtask

  task automatic drive();
    reset = s_reset;
    bus32.valid_d = s_valid;           bus16.valid_d = s_valid;
    bus32.instruction = s_instr;       bus16.instruction = s_instr;
    bus32.pc = s_pc;                   bus16.pc = s_pc;
    bus32.pc_plus_4 = s_pc4;           bus16.pc_plus_4 = s_pc4;
    bus32.ctrl_i = s_ctrl;             bus16.ctrl_i = s_ctrl;
    bus32.imm_i = s_imm;               bus16.imm_i = s_imm;
    bus32.writeback_control = s_wbc;   bus16.writeback_control = s_wbc;
    bus32.rd = s_rd;                   bus16.rd = s_rd;
    bus32.writeback_data = s_wbd;      bus16.writeback_data = s_wbd;
    bus32.stall_d = s_stall;           bus16.stall_d = s_stall;
    bus32.flush_d = s_flush;           bus16.flush_d = s_flush;
    #1;
    check("n32.rs1_wire", 64'(bus32.id_ex_rs1_d_wire), 64'(s_instr[19:15]));
    check("n32.rs2_wire", 64'(bus32.id_ex_rs2_d_wire), 64'(s_instr[24:20]));
    check("n16.rs1_wire", 64'(bus16.id_ex_rs1_d_wire), 64'(s_instr[19:15]));
    check("n16.rs2_wire", 64'(bus16.id_ex_rs2_d_wire), 64'(s_instr[24:20]));
  endtask

  task automatic cycle();
    exp_t o;
    drive();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    o = {bus32.valid_e, bus32.ctrl_e, bus32.immediate, bus32.rs1_data, bus32.rs2_data,
         bus32.rd_out, bus32.id_ex_rs1_d_reg, bus32.id_ex_rs2_d_reg, bus32.id_ex_pc,
         bus32.id_ex_pc_plus_4, bus32.illegal_reg_e};
    compare("n32", o, m_exp[0]);
    o = {bus16.valid_e, bus16.ctrl_e, bus16.immediate, bus16.rs1_data, bus16.rs2_data,
         bus16.rd_out, bus16.id_ex_rs1_d_reg, bus16.id_ex_rs2_d_reg, bus16.id_ex_pc,
         bus16.id_ex_pc_plus_4, bus16.illegal_reg_e};
    compare("n16", o, m_exp[1]);
  endtask

  task automatic idle();
    s_reset = 1'b0;  s_valid = 1'b1;  s_wbc = 1'b0;  s_stall = 1'b0;  s_flush = 1'b0;
    s_instr = $urandom;  s_pc = $urandom;  s_pc4 = $urandom;  s_imm = $urandom;
    s_ctrl = CTRL_W'($urandom);  s_rd = 5'($urandom);  s_wbd = $urandom;
  endtask

  task automatic set_instr(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
    s_instr = $urandom;
    s_instr[19:15] = a;
    s_instr[24:20] = b;
    s_instr[11:7]  = d;
  endtask

  task automatic write_reg(input logic [4:0] r, input logic [XLEN-1:0] v);
    idle();
    set_instr(5'd0, 5'd0, 5'd1);
    s_wbc = 1'b1;  s_rd = r;  s_wbd = v;
    cycle();
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_exp[k] = '0;
      for (int i = 0; i < 32; i++) m_rf[k][i] = '0;
    end

    // Reset with arbitrary inputs, including a pending writeback.
    idle();
    s_reset = 1'b1;  s_wbc = 1'b1;  s_stall = 1'b1;
    cycle();
    check("reset.valid_e", 64'(bus32.valid_e), 64'(0));

    // Every register reads zero after reset.
    for (int i = 1; i < 32; i++) begin
      idle();
      set_instr(5'(i), 5'(32 - i), 5'(i));
      cycle();
    end

    write_reg(5'd5, 32'hDEADBEEF);
    idle();
    set_instr(5'd5, 5'd0, 5'd2);
    cycle();
    check("x5_read", 64'(bus32.rs1_data), 64'h0000_0000_DEAD_BEEF);
    check("x0_rs2", 64'(bus32.rs2_data), 64'(0));

    write_reg(5'd0, 32'h1234);
    idle();
    set_instr(5'd0, 5'd0, 5'd3);
    cycle();
    check("x0_read", 64'(bus32.rs1_data), 64'(0));

    // Same-edge write-through bypass.
    idle();
    set_instr(5'd1, 5'd7, 5'd4);
    s_wbc = 1'b1;  s_rd = 5'd7;  s_wbd = 32'h55AA;
    cycle();
    check("bypass_rs2", 64'(bus32.rs2_data), 64'h55AA);

    // Held operand follows a writeback during a stall.
    write_reg(5'd3, 32'h10);
    idle();
    set_instr(5'd3, 5'd0, 5'd6);
    cycle();
    check("stall_pre", 64'(bus32.rs1_data), 64'h10);
    idle();
    s_stall = 1'b1;  s_wbc = 1'b1;  s_rd = 5'd3;  s_wbd = 32'h20;
    cycle();
    check("stall_refresh", 64'(bus32.rs1_data), 64'h20);
    idle();
    s_stall = 1'b1;
    cycle();

    // Flush wins over stall; the concurrent writeback still commits.
    idle();
    s_flush = 1'b1;  s_stall = 1'b1;  s_wbc = 1'b1;  s_rd = 5'd9;  s_wbd = 32'h77;
    cycle();
    check("flush_valid", 64'(bus32.valid_e), 64'(0));
    check("flush_ctrl", 64'(bus32.ctrl_e), 64'(0));
    idle();
    set_instr(5'd9, 5'd9, 5'd9);
    cycle();
    check("x9_read", 64'(bus32.rs1_data), 64'h77);

    // RV32E: out-of-range rd flagged; high writeback index does not alias.
    idle();
    set_instr(5'd1, 5'd2, 5'd17);
    cycle();
    check("n16.illegal_rd17", 64'(bus16.illegal_reg_e), 64'(1));
    check("n32.legal_rd17", 64'(bus32.illegal_reg_e), 64'(0));
    write_reg(5'd4, 32'hAB);
    write_reg(5'd20, 32'hCAFE);
    idle();
    set_instr(5'd4, 5'd20, 5'd1);
    cycle();
    check("n16.x4_kept", 64'(bus16.rs1_data), 64'hAB);
    check("n16.x20_zero", 64'(bus16.rs2_data), 64'(0));
    check("n32.x20", 64'(bus32.rs2_data), 64'hCAFE);

    // Reset asserted together with stall and flush.
    idle();
    s_reset = 1'b1;  s_stall = 1'b1;  s_flush = 1'b1;  s_wbc = 1'b1;  s_rd = 5'd9;
    cycle();
    idle();
    set_instr(5'd9, 5'd4, 5'd1);
    cycle();
    check("post_reset_x9", 64'(bus32.rs1_data), 64'(0));

    // Randomised traffic with biased register indices so hits are frequent.
    for (int t = 0; t < 400; t++) begin
      idle();
      s_valid = 1'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        s_instr[19:15] = 5'($urandom_range(0, 7));
        s_instr[24:20] = 5'($urandom_range(0, 7));
      end
      s_wbc = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       s_rd = s_instr[19:15];
        1:       s_rd = m_exp[0].rs1r;
        default: s_rd = 5'($urandom);
      endcase
      s_stall = ($urandom_range(0, 4) == 0);
      s_flush = ($urandom_range(0, 11) == 0);
      s_reset = ($urandom_range(0, 59) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
